pci_initiator: RTL and testbench
================================

# pci_initiator

PCI bus initiator (master) that runs single and burst write/read transactions against the PCI target device over the shared FRAME#/IRDY#/TRDY#/DEVSEL#/AD/CBE bus. A local client queues write words in an 8-deep FIFO, issues a start request with command, address and burst length, and receives read words on a valid strobe. The block owns address phase, bus turnaround, data-phase handshaking, frame termination and master abort.

## Interface

Parameters:
- DEPTH, 8, write FIFO depth and maximum burst length in words
- DEVSEL_TIMEOUT, 5, clocks after the address phase before master abort

Ports:
- CLK  in  1  bus clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  transaction request, accepted only in IDLE
- wr_cmd  in  1  1 = memory write (cbe 4'b0111), 0 = memory read (cbe 4'b0110)
- addr  in  32  start address, captured on accept
- len_m1  in  3  burst length minus 1 (1..8 words), captured on accept
- rd_be  in  4  byte enables (active-low) for all read data phases, captured on accept
- wr_push  in  1  push {wbe, wdata} into write FIFO; ignored when wr_full
- wdata  in  32  write data word
- wbe  in  4  byte enables (active-low) for that word
- frame  out  1  FRAME#, active-low
- irdy  out  1  IRDY#, active-low
- cbe  out  4  command in address phase, byte enables in data phases
- ad  inout  32  multiplexed address/data; driven only while enable = 1, else high-Z
- enable  out  1  1 = initiator drives ad (direction control shared with the target)
- trdy  in  1  TRDY# from target, active-low
- devsel  in  1  DEVSEL# from target, active-low
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- abort  out  1  with done: transaction ended by master abort
- rdata  out  32  read word
- rvalid  out  1  one-cycle pulse, rdata valid
- wr_level  out  4  write FIFO occupancy 0..8
- wr_full  out  1  wr_level == 8

## Operation

- States: IDLE, ADDR, TURN (read only), DATA, RELEASE.
- IDLE: start accepted if wr_cmd = 0, or wr_cmd = 1 and wr_level >= len_m1+1; otherwise ignored (no done). Accept captures addr, cmd, len, rd_be; busy = 1 next cycle.
- ADDR (1 cycle): frame = 0, irdy = 1, enable = 1, ad = addr, cbe = command. Write -> DATA; read -> TURN.
- TURN (1 cycle): frame = 0, irdy = 0, enable = 0, cbe = rd_be -> DATA.
- DATA write: irdy = 0, enable = 1, ad/cbe = FIFO head. Read: irdy = 0, enable = 0, cbe = rd_be.
- Transfer = rising edge with irdy = 0 and trdy = 0. Write: FIFO pops. Read: rdata <= ad, rvalid = 1 next cycle. Remaining count decrements.
- frame = 1 while the last word is presented (remaining == 1); irdy stays 0 until that transfer.
- After last transfer -> RELEASE: frame = 1, irdy = 1, enable = 0, cbe = 4'hF; done = 1; then IDLE.
- Master abort: devsel = 1 for DEVSEL_TIMEOUT consecutive clocks counted from the first clock after ADDR -> frame = 1 one cycle, then RELEASE with abort = 1 and done = 1. On write abort, the unsent words of that burst are flushed from the FIFO.
- wr_push during DATA is allowed; simultaneous push and pop keep wr_level unchanged. FIFO pointers are 3-bit and wrap modulo 8.

## Timing

- Reset values (asynchronous): frame = 1, irdy = 1, cbe = 4'hF, enable = 0, ad = high-Z, busy = 0, done = 0, abort = 0, rvalid = 0, rdata = 0, wr_level = 0, state IDLE.
- Reset asserted mid-transaction releases the bus immediately, flushes the FIFO, and produces no done.
- Latency: start to ADDR is 1 clock. Zero-wait-state write of N words completes in N+1 clocks from ADDR to done. Zero-wait-state read completes in N+2 clocks.
- trdy = 1 inserts wait states: outputs hold and no transfer occurs.
- done, rvalid, abort are registered single-cycle pulses. abort is valid only while done = 1.

## Test plan

- Write burst: push 4 words (0x191, 0x5555, 0x5565, 0x100) with wbe 4'b1010/1001/1001/1000; start wr_cmd = 1, addr 0, len_m1 = 3; target holds trdy = devsel = 0. Expect ad/cbe sequence 0/0111 then the four words in order, frame = 1 on the 4th word, done 5 clocks after ADDR, wr_level = 0.
- Read burst: len_m1 = 2, target returns 0xA, 0xB, 0xC. Expect TURN cycle with enable = 0, three rvalid pulses in order, and done.
- Wait states: write of 2 words with trdy = 1 for 2 clocks before each word. Expect ad held stable, FIFO pops only on trdy = 0 edges.
- Master abort: devsel held 1. Expect frame = 1 at clock 5 after ADDR, then done = 1 with abort = 1; unsent FIFO words flushed.
- Refused start: wr_level = 2, start with len_m1 = 3. Expect no ADDR and busy stays 0. Push an 8th word to a full FIFO: ignored, wr_full = 1.
- Reset mid-read after the first transfer. Expect frame = irdy = 1, enable = 0 asynchronously, no done; the next read runs normally.

Source files
------------

// File: rtl/pci_initiator.sv
// PCI bus initiator: single and burst memory read/write with a FIFO-fed write path,
// target wait states, frame termination and master abort on a DEVSEL# timeout.
module pci_initiator #(
  parameter int DEPTH          = 8,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        wr_cmd,
  input  logic [31:0] addr,
  input  logic [2:0]  len_m1,
  input  logic [3:0]  rd_be,
  input  logic        wr_push,
  input  logic [31:0] wdata,
  input  logic [3:0]  wbe,
  output logic        frame,
  output logic        irdy,
  output logic [3:0]  cbe,
  inout  wire  [31:0] ad,
  output logic        enable,
  input  logic        trdy,
  input  logic        devsel,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic [3:0]  wr_level,
  output logic        wr_full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEVSEL_TIMEOUT + 1);
  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DEVSEL_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, TURN, DATA, MABORT, RELEASE} state_t;
  state_t state_reg;

  logic [35:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [3:0]       level_reg;

  logic [3:0]       remaining_reg;
  logic [CNT_W-1:0] to_cnt_reg;
  logic             devsel_seen_reg;
  logic             is_write_reg;
  logic [3:0]       be_reg;

  logic             frame_reg, irdy_reg, enable_reg, busy_reg;
  logic             done_reg, abort_reg, rvalid_reg;
  logic [3:0]       cbe_reg;
  logic [31:0]      ad_reg, rdata_reg;

  logic             push_ok, accept, xfer, pop, active, timeout_hit, flush;
  logic [3:0]       len_words, pop_count;
  logic [35:0]      head, head_next;

  assign wr_full   = (level_reg == 4'(DEPTH));
  assign push_ok   = wr_push && !wr_full;
  assign len_words = {1'b0, len_m1} + 4'd1;
  assign accept    = start && (!wr_cmd || (level_reg >= len_words));
  assign xfer      = (state_reg == DATA) && !irdy_reg && !trdy;
  assign pop       = xfer && is_write_reg;
  assign active    = (state_reg == ADDR) || (state_reg == TURN) || (state_reg == DATA);
  // A completing transfer wins over a timeout landing on the same edge.
  assign timeout_hit = active && devsel && !devsel_seen_reg &&
                       (to_cnt_reg == TIMEOUT_LAST) && !xfer;
  assign flush     = timeout_hit && is_write_reg;
  assign head      = mem[rd_ptr_reg];
  assign head_next = mem[rd_ptr_reg + PTR_W'(1)];

  always_comb begin
    pop_count = 4'd0;
    if (flush)
      pop_count = remaining_reg;
    else if (pop)
      pop_count = 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (push_ok)
      mem[wr_ptr_reg] <= {wbe, wdata};
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= 4'd0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg <= rd_ptr_reg + pop_count[PTR_W-1:0];
      level_reg  <= level_reg + {3'b000, push_ok} - pop_count;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      remaining_reg   <= 4'd0;
      to_cnt_reg      <= '0;
      devsel_seen_reg <= 1'b0;
      is_write_reg    <= 1'b0;
      be_reg          <= 4'hF;
      frame_reg       <= 1'b1;
      irdy_reg        <= 1'b1;
      enable_reg      <= 1'b0;
      cbe_reg         <= 4'hF;
      ad_reg          <= 32'd0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      abort_reg       <= 1'b0;
      rvalid_reg      <= 1'b0;
      rdata_reg       <= 32'd0;
    end else begin
      done_reg   <= 1'b0;
      abort_reg  <= 1'b0;
      rvalid_reg <= 1'b0;

      if (active) begin
        if (!devsel)
          devsel_seen_reg <= 1'b1;
        else if (!devsel_seen_reg)
          to_cnt_reg <= to_cnt_reg + CNT_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg       <= ADDR;
            is_write_reg    <= wr_cmd;
            be_reg          <= rd_be;
            remaining_reg   <= len_words;
            to_cnt_reg      <= '0;
            devsel_seen_reg <= 1'b0;
            frame_reg       <= 1'b0;
            irdy_reg        <= 1'b1;
            enable_reg      <= 1'b1;
            ad_reg          <= addr;
            cbe_reg         <= wr_cmd ? CMD_MEM_WRITE : CMD_MEM_READ;
            busy_reg        <= 1'b1;
          end
        end

        ADDR: begin
          irdy_reg <= 1'b0;
          if (timeout_hit) begin
            state_reg <= MABORT;
            frame_reg <= 1'b1;
          end else if (is_write_reg) begin
            state_reg <= DATA;
            frame_reg <= (remaining_reg == 4'd1);
            ad_reg    <= head[31:0];
            cbe_reg   <= head[35:32];
          end else begin
            state_reg  <= TURN;
            enable_reg <= 1'b0;
            cbe_reg    <= be_reg;
          end
        end

        TURN: begin
          if (timeout_hit) begin
            state_reg <= MABORT;
            frame_reg <= 1'b1;
          end else begin
            state_reg <= DATA;
            frame_reg <= (remaining_reg == 4'd1);
          end
        end

        DATA: begin
          if (xfer) begin
            remaining_reg <= remaining_reg - 4'd1;
            if (!is_write_reg) begin
              rdata_reg  <= ad;
              rvalid_reg <= 1'b1;
            end
            if (remaining_reg == 4'd1) begin
              state_reg  <= RELEASE;
              frame_reg  <= 1'b1;
              irdy_reg   <= 1'b1;
              enable_reg <= 1'b0;
              cbe_reg    <= 4'hF;
              done_reg   <= 1'b1;
            end else begin
              // Deassert FRAME# as soon as the final word goes on the bus.
              frame_reg <= (remaining_reg == 4'd2);
              if (is_write_reg) begin
                ad_reg  <= head_next[31:0];
                cbe_reg <= head_next[35:32];
              end
            end
          end else if (timeout_hit) begin
            state_reg <= MABORT;
            frame_reg <= 1'b1;
          end
        end

        MABORT: begin
          state_reg  <= RELEASE;
          irdy_reg   <= 1'b1;
          enable_reg <= 1'b0;
          cbe_reg    <= 4'hF;
          done_reg   <= 1'b1;
          abort_reg  <= 1'b1;
        end

        RELEASE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ad       = enable_reg ? ad_reg : {32{1'bz}};
  assign frame    = frame_reg;
  assign irdy     = irdy_reg;
  assign cbe      = cbe_reg;
  assign enable   = enable_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign abort    = abort_reg;
  assign rdata    = rdata_reg;
  assign rvalid   = rvalid_reg;
  assign wr_level = level_reg;
endmodule

// File: tb/tb_pci_initiator.sv
// Directed bench for pci_initiator: bus-level cycle checks for bursts, wait states,
// master abort, refused starts, FIFO full and asynchronous reset.
module tb_pci_initiator;
  logic        CLK = 1'b0;
  logic        reset;
  logic        start, wr_cmd, wr_push, trdy, devsel;
  logic [31:0] addr, wdata;
  logic [2:0]  len_m1;
  logic [3:0]  rd_be, wbe;
  logic        frame, irdy, enable, busy, done, abort, rvalid, wr_full;
  logic [3:0]  cbe, wr_level;
  logic [31:0] rdata;
  wire  [31:0] ad;
  logic        tgt_oe;
  logic [31:0] tgt_data;

  int compared   = 0;
  int mismatched = 0;

  assign ad = (tgt_oe && !enable) ? tgt_data : {32{1'bz}};

  pci_initiator #(.DEPTH(8), .DEVSEL_TIMEOUT(5)) dut (
    .CLK(CLK), .reset(reset), .start(start), .wr_cmd(wr_cmd), .addr(addr),
    .len_m1(len_m1), .rd_be(rd_be), .wr_push(wr_push), .wdata(wdata), .wbe(wbe),
    .frame(frame), .irdy(irdy), .cbe(cbe), .ad(ad), .enable(enable),
    .trdy(trdy), .devsel(devsel), .busy(busy), .done(done), .abort(abort),
    .rdata(rdata), .rvalid(rvalid), .wr_level(wr_level), .wr_full(wr_full)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] b);
    wr_push = 1'b1; wdata = d; wbe = b;
    tick();
    wr_push = 1'b0;
  endtask

  task automatic begin_txn(input logic w, input logic [31:0] a, input logic [2:0] l,
                           input logic [3:0] be);
    start = 1'b1; wr_cmd = w; addr = a; len_m1 = l; rd_be = be;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; wr_cmd = 1'b0; addr = 32'd0; len_m1 = 3'd0;
    rd_be = 4'hF; wr_push = 1'b0; wdata = 32'd0; wbe = 4'hF;
    trdy = 1'b1; devsel = 1'b1; tgt_oe = 1'b0; tgt_data = 32'd0;

    // Reset state
    tick(); tick();
    check("rst_frame", 36'(frame), 36'(1));
    check("rst_irdy", 36'(irdy), 36'(1));
    check("rst_cbe", 36'(cbe), 36'hF);
    check("rst_enable", 36'(enable), 36'(0));
    check("rst_busy", 36'(busy), 36'(0));
    check("rst_done", 36'(done), 36'(0));
    check("rst_abort", 36'(abort), 36'(0));
    check("rst_rvalid", 36'(rvalid), 36'(0));
    check("rst_rdata", 36'(rdata), 36'(0));
    check("rst_level", 36'(wr_level), 36'(0));
    reset = 1'b0;
    tick();

    // Zero-wait write burst of 4 words
    push(32'h191, 4'b1010); push(32'h5555, 4'b1001);
    push(32'h5565, 4'b1001); push(32'h100, 4'b1000);
    check("wr_level_4", 36'(wr_level), 36'(4));
    trdy = 1'b0; devsel = 1'b0;
    begin_txn(1'b1, 32'h0, 3'd3, 4'hF);
    check("wr_addr_frame", 36'(frame), 36'(0));
    check("wr_addr_irdy", 36'(irdy), 36'(1));
    check("wr_addr_en", 36'(enable), 36'(1));
    check("wr_addr_ad", 36'(ad), 36'h0);
    check("wr_addr_cbe", 36'(cbe), 36'h7);
    check("wr_busy", 36'(busy), 36'(1));
    tick();
    check("wr_d0", {cbe, ad}, {4'b1010, 32'h191});
    check("wr_d0_frame", 36'(frame), 36'(0));
    check("wr_d0_irdy", 36'(irdy), 36'(0));
    tick();
    check("wr_d1", {cbe, ad}, {4'b1001, 32'h5555});
    check("wr_d1_level", 36'(wr_level), 36'(3));
    tick();
    check("wr_d2", {cbe, ad}, {4'b1001, 32'h5565});
    check("wr_d2_frame", 36'(frame), 36'(0));
    tick();
    check("wr_d3", {cbe, ad}, {4'b1000, 32'h100});
    check("wr_d3_frame", 36'(frame), 36'(1));
    tick();
    check("wr_done", 36'(done), 36'(1));
    check("wr_done_abort", 36'(abort), 36'(0));
    check("wr_rel_bus", {frame, irdy, enable, cbe}, {1'b1, 1'b1, 1'b0, 4'hF});
    check("wr_level_0", 36'(wr_level), 36'(0));
    tick();
    check("wr_done_pulse", 36'(done), 36'(0));
    check("wr_idle_busy", 36'(busy), 36'(0));
    $display("txn: write burst 4 words addr 0");

    // Zero-wait read burst of 3 words
    begin_txn(1'b0, 32'h1000, 3'd2, 4'b0000);
    check("rd_addr", {cbe, ad}, {4'h6, 32'h1000});
    tgt_oe = 1'b1; tgt_data = 32'hA;
    tick();
    check("rd_turn_bus", {frame, irdy, enable, cbe}, {1'b0, 1'b0, 1'b0, 4'h0});
    tick();
    check("rd_data_frame", 36'(frame), 36'(0));
    check("rd_data_rvalid", 36'(rvalid), 36'(0));
    tick();
    check("rd_w0", {3'b000, rvalid, rdata}, {4'h1, 32'hA});
    tgt_data = 32'hB;
    tick();
    check("rd_w1", {3'b000, rvalid, rdata}, {4'h1, 32'hB});
    check("rd_w1_frame", 36'(frame), 36'(1));
    tgt_data = 32'hC;
    tick();
    check("rd_w2", {3'b000, rvalid, rdata}, {4'h1, 32'hC});
    check("rd_done", {done, abort}, {1'b1, 1'b0});
    tick();
    check("rd_after", {rvalid, done}, {1'b0, 1'b0});
    tgt_oe = 1'b0;
    $display("txn: read burst 3 words addr 1000");

    // Write with two wait states ahead of each word
    push(32'h11, 4'h0); push(32'h22, 4'h3);
    trdy = 1'b1;
    begin_txn(1'b1, 32'h40, 3'd1, 4'hF);
    tick();
    check("ws_d0", {cbe, ad}, {4'h0, 32'h11});
    tick();
    check("ws_hold0a", {cbe, ad}, {4'h0, 32'h11});
    check("ws_level_a", 36'(wr_level), 36'(2));
    tick();
    check("ws_hold0b", {cbe, ad}, {4'h0, 32'h11});
    trdy = 1'b0;
    tick();
    check("ws_d1", {cbe, ad}, {4'h3, 32'h22});
    check("ws_d1_frame", 36'(frame), 36'(1));
    check("ws_level_b", 36'(wr_level), 36'(1));
    trdy = 1'b1;
    tick();
    check("ws_hold1a", {cbe, ad}, {4'h3, 32'h22});
    tick();
    check("ws_hold1b", 36'(ad), 36'h22);
    check("ws_hold_done", 36'(done), 36'(0));
    check("ws_level_c", 36'(wr_level), 36'(1));
    trdy = 1'b0;
    tick();
    check("ws_done", 36'(done), 36'(1));
    check("ws_level_0", 36'(wr_level), 36'(0));
    tick();
    $display("txn: write 2 words with wait states addr 40");

    // Master abort on a 3-word write
    push(32'h31, 4'h1); push(32'h32, 4'h2); push(32'h33, 4'h3);
    devsel = 1'b1; trdy = 1'b1;
    begin_txn(1'b1, 32'h80, 3'd2, 4'hF);
    check("ab_addr_frame", 36'(frame), 36'(0));
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("ab_wait%0d", i), {frame, done}, {1'b0, 1'b0});
    end
    tick();
    check("ab_frame", {frame, done}, {1'b1, 1'b0});
    check("ab_flush", 36'(wr_level), 36'(0));
    tick();
    check("ab_done", {done, abort}, {1'b1, 1'b1});
    check("ab_rel_bus", {frame, irdy, enable}, {1'b1, 1'b1, 1'b0});
    tick();
    check("ab_after", {done, abort, busy}, {1'b0, 1'b0, 1'b0});
    $display("txn: write 3 words master abort addr 80");

    // Refused start, FIFO full, then an 8-word burst across the pointer wrap
    push(32'hC0, 4'h0); push(32'hC1, 4'h1);
    begin_txn(1'b1, 32'h100, 3'd3, 4'hF);
    check("ref_busy", 36'(busy), 36'(0));
    check("ref_bus", {frame, enable}, {1'b1, 1'b0});
    tick();
    check("ref_busy2", {busy, done}, {1'b0, 1'b0});
    $display("txn: refused write start level 2 len 4");
    for (int i = 2; i < 8; i++) push(32'hC0 + i, 4'(i));
    check("full_level", 36'(wr_level), 36'(8));
    check("full_flag", 36'(wr_full), 36'(1));
    push(32'hDEAD, 4'hF);
    check("full_ignore", 36'(wr_level), 36'(8));
    check("full_flag2", 36'(wr_full), 36'(1));
    devsel = 1'b0; trdy = 1'b0;
    begin_txn(1'b1, 32'h200, 3'd7, 4'hF);
    check("b8_addr", {cbe, ad}, {4'h7, 32'h200});
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        wr_push = 1'b1; wdata = 32'hEE; wbe = 4'h5;
      end
      tick();
      wr_push = 1'b0;
      check($sformatf("b8_d%0d", k), {cbe, ad}, {4'(k), 32'hC0 + k});
      check($sformatf("b8_frame%0d", k), 36'(frame), 36'(k == 7));
      if (k == 1 || k == 2)
        check($sformatf("b8_level%0d", k), 36'(wr_level), 36'(7));
    end
    tick();
    check("b8_done", 36'(done), 36'(1));
    check("b8_level_end", 36'(wr_level), 36'(1));
    tick();
    $display("txn: write burst 8 words addr 200");

    // Reset in the middle of a read, then a normal single read
    tgt_oe = 1'b1; tgt_data = 32'h111;
    begin_txn(1'b0, 32'h300, 3'd3, 4'b0011);
    check("rr_addr_cbe", 36'(cbe), 36'h6);
    tick();
    check("rr_turn_cbe", {enable, cbe}, {1'b0, 4'b0011});
    tick();
    tick();
    check("rr_w0", {3'b000, rvalid, rdata}, {4'h1, 32'h111});
    #2 reset = 1'b1;
    #1;
    check("rr_async_bus", {frame, irdy, enable, cbe}, {1'b1, 1'b1, 1'b0, 4'hF});
    check("rr_async_state", {busy, done, rvalid, wr_level}, 7'd0);
    check("rr_async_rdata", 36'(rdata), 36'(0));
    tick();
    reset = 1'b0;
    tick();
    check("rr_no_done", {done, busy}, {1'b0, 1'b0});
    $display("txn: read 4 words reset after first word");
    tgt_data = 32'h12345678;
    begin_txn(1'b0, 32'h400, 3'd0, 4'h0);
    check("r1_addr", {cbe, ad}, {4'h6, 32'h400});
    tick();
    tick();
    check("r1_data_bus", {frame, irdy, enable}, {1'b1, 1'b0, 1'b0});
    tick();
    check("r1_word", {3'b000, rvalid, rdata}, {4'h1, 32'h12345678});
    check("r1_done", {done, abort}, {1'b1, 1'b0});
    tick();
    check("r1_after", {done, rvalid, busy}, {1'b0, 1'b0, 1'b0});
    tgt_oe = 1'b0;
    $display("txn: read 1 word addr 400");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
